// File: rtl/register_bank.sv
// CPU register block: IR, PC, general registers, flags and a
// one-deep buffered output port with valid/ready and sticky overrun.
module register_bank #(
  parameter int               WIDTH    = 8,
  parameter int               NREGS    = 4,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_ir,
  input  logic                   load_pc,
  input  logic                   jump_ok,
  input  logic                   pc_inc,
  input  logic [NREGS-1:0]       reg_we,
  input  logic                   do_out,
  input  logic                   out_ready,
  input  logic                   overrun_clr,
  input  logic                   flag_we,
  input  logic                   carry_in,
  input  logic                   zero_in,
  input  logic [WIDTH-1:0]       dbus,
  input  logic [WIDTH-1:0]       abus,
  output logic [WIDTH-1:0]       ir,
  output logic [WIDTH-1:0]       pc,
  output logic [NREGS*WIDTH-1:0] regs,
  output logic [WIDTH-1:0]       qreg,
  output logic                   out_valid,
  output logic                   out_overrun,
  output logic                   flag_carry,
  output logic                   flag_zero
);

  logic jump;
  logic accept;
  logic space;
  logic drop;

  assign jump   = load_pc & jump_ok;
  assign accept = out_valid & out_ready;
  assign space  = ~out_valid | out_ready;
  assign drop   = do_out & ~space;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir <= '0;
    end else begin
      ir <= load_ir ? dbus : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= PC_RESET;
    end else if (jump) begin
      pc <= abus;
    end else if (pc_inc) begin
      pc <= pc + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (reg_we[i]) begin
          regs[i*WIDTH +: WIDTH] <= dbus;
        end
      end
    end
  end

  // qreg only changes on a successful capture, so it holds while unaccepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qreg      <= '0;
      out_valid <= 1'b0;
    end else if (do_out && space) begin
      qreg      <= dbus;
      out_valid <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

  // A dropped write in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_overrun <= 1'b0;
    end else if (drop) begin
      out_overrun <= 1'b1;
    end else if (overrun_clr) begin
      out_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_carry <= 1'b0;
      flag_zero  <= 1'b0;
    end else if (flag_we) begin
      flag_carry <= carry_in;
      flag_zero  <= zero_in;
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: directed scenarios plus a randomized run
// compared against a behavioural model of the register block.
module tb_register_bank;

  localparam int W = 8;
  localparam int N = 4;
  localparam logic [W-1:0] PCR = 8'h00;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           load_ir = 0, load_pc = 0, jump_ok = 0, pc_inc = 0;
  logic [N-1:0]   reg_we = '0;
  logic           do_out = 0, out_ready = 0, overrun_clr = 0;
  logic           flag_we = 0, carry_in = 0, zero_in = 0;
  logic [W-1:0]   dbus = '0, abus = '0;
  logic [W-1:0]   ir, pc, qreg;
  logic [N*W-1:0] regs;
  logic           out_valid, out_overrun, flag_carry, flag_zero;

  int checks = 0;
  int failures = 0;
  int accepts = 0;

  // behavioural model
  int m_pc, m_ir, m_q;
  int m_regs[N];
  bit m_v, m_ov, m_c, m_z;

  register_bank #(.WIDTH(W), .NREGS(N), .PC_RESET(PCR)) dut (
    .clk(clk), .reset(reset),
    .load_ir(load_ir), .load_pc(load_pc), .jump_ok(jump_ok),
    .pc_inc(pc_inc), .reg_we(reg_we), .do_out(do_out),
    .out_ready(out_ready), .overrun_clr(overrun_clr),
    .flag_we(flag_we), .carry_in(carry_in), .zero_in(zero_in),
    .dbus(dbus), .abus(abus),
    .ir(ir), .pc(pc), .regs(regs), .qreg(qreg),
    .out_valid(out_valid), .out_overrun(out_overrun),
    .flag_carry(flag_carry), .flag_zero(flag_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] exp_regs();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(m_regs[i]);
    return v;
  endfunction

  function automatic logic [6*W+4-1+N*W-W*0:0] exp_all();
    return {W'(m_ir), W'(m_pc), exp_regs(), W'(m_q),
            m_v, m_ov, m_c, m_z};
  endfunction

  task automatic model_reset();
    m_pc = int'(PCR); m_ir = 0; m_q = 0;
    m_v = 0; m_ov = 0; m_c = 0; m_z = 0;
    for (int i = 0; i < N; i++) m_regs[i] = 0;
  endtask

  task automatic idle();
    load_ir = 0; load_pc = 0; jump_ok = 0; pc_inc = 0;
    reg_we = '0; do_out = 0; out_ready = 0; overrun_clr = 0;
    flag_we = 0; carry_in = 0; zero_in = 0;
    dbus = '0; abus = '0;
  endtask

  // one clock: model consumes the inputs that are stable before the edge
  task automatic step();
    bit was_full, taken;
    if (out_valid && out_ready) accepts++;
    m_ir = load_ir ? int'(dbus) : 0;
    if (load_pc && jump_ok) m_pc = int'(abus);
    else if (pc_inc) m_pc = (m_pc + 1) % (1 << W);
    for (int i = 0; i < N; i++) if (reg_we[i]) m_regs[i] = int'(dbus);
    was_full = m_v && !out_ready;
    taken = 0;
    if (do_out) begin
      if (was_full) m_ov = 1;
      else begin m_q = int'(dbus); m_v = 1; taken = 1; end
    end
    if (!taken && m_v && out_ready) m_v = 0;
    if (overrun_clr && !(do_out && was_full)) m_ov = 0;
    if (flag_we) begin m_c = carry_in; m_z = zero_in; end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    model_reset();
    #1;
    if (pc !== PCR || out_valid !== 1'b0 || regs !== '0) begin
      failures++;
      $display("FAIL reset_init pc=%h valid=%b regs=%h want pc=%h 0 0", pc, out_valid, regs, PCR);
    end
    checks++;
    @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
    load_pc = 1; jump_ok = 1; abus = 8'h37;
    do_out = 1; dbus = 8'h5A;
    step();
    idle();
    if (pc !== 8'h37 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_setup pc=%h valid=%b want 37 1", pc, out_valid);
    end
    checks++;
    #2;
    reset = 1;
    model_reset();
    #1;
    if (pc !== PCR || out_valid !== 1'b0 || qreg !== 8'h00) begin
      failures++;
      $display("FAIL reset_async pc=%h valid=%b q=%h want %h 0 00", pc, out_valid, qreg, PCR);
    end
    checks++;
    reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_pc();
    idle(); load_pc = 1; jump_ok = 1; abus = 8'hFF; step();
    idle(); pc_inc = 1; step();
    if (pc !== 8'h00) begin
      failures++; $display("FAIL pc_wrap got=%h want=00", pc);
    end
    checks++;
    idle(); load_pc = 1; jump_ok = 1; pc_inc = 1; abus = 8'h40; step();
    if (pc !== 8'h40) begin
      failures++; $display("FAIL pc_jump_prio got=%h want=40", pc);
    end
    checks++;
    idle(); load_pc = 1; jump_ok = 0; pc_inc = 1; abus = 8'h99; step();
    if (pc !== 8'h41) begin
      failures++; $display("FAIL pc_jump_not_ok got=%h want=41", pc);
    end
    checks++;
    idle(); step();
    if (pc !== 8'h41) begin
      failures++; $display("FAIL pc_hold got=%h want=41", pc);
    end
    checks++;
  endtask

  task automatic test_regs_ir();
    idle(); reg_we = 4'b1010; dbus = 8'h3C; load_ir = 1; step();
    if (ir !== 8'h3C) begin
      failures++; $display("FAIL ir_load got=%h want=3C", ir);
    end
    checks++;
    idle(); reg_we = 4'b0101; dbus = 8'hA5; step();
    if (regs !== 32'h3CA5_3CA5) begin
      failures++; $display("FAIL regs_multi got=%h want=3ca53ca5", regs);
    end
    checks++;
    if (ir !== 8'h00) begin
      failures++; $display("FAIL ir_nop got=%h want=00", ir);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    idle(); out_ready = 1; step();
    accepts = 0;
    do_out = 1; dbus = 8'h11; step();
    dbus = 8'h22; step();
    dbus = 8'h33; step();
    do_out = 0; step();
    if (accepts !== 3 || out_overrun !== 1'b0) begin
      failures++; $display("FAIL b2b_accepts got=%0d ov=%b want 3 0", accepts, out_overrun);
    end
    checks++;
    if (out_valid !== 1'b0 || qreg !== 8'h33) begin
      failures++; $display("FAIL b2b_drain valid=%b q=%h want 0 33", out_valid, qreg);
    end
    checks++;
  endtask

  task automatic test_overrun();
    idle(); do_out = 1; dbus = 8'h11; step();
    dbus = 8'h22; step();
    idle();
    if (qreg !== 8'h11 || out_overrun !== 1'b1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set q=%h ov=%b v=%b want 11 1 1", qreg, out_overrun, out_valid);
    end
    checks++;
    do_out = 1; dbus = 8'h77; overrun_clr = 1; step();
    if (out_overrun !== 1'b1 || qreg !== 8'h11) begin
      failures++; $display("FAIL overrun_set_wins ov=%b q=%h want 1 11", out_overrun, qreg);
    end
    checks++;
    idle(); overrun_clr = 1; step();
    if (out_overrun !== 1'b0) begin
      failures++; $display("FAIL overrun_clr got=%b want=0", out_overrun);
    end
    checks++;
  endtask

  task automatic test_flags();
    idle(); flag_we = 1; carry_in = 1; zero_in = 1; step();
    idle(); step();
    if (flag_carry !== 1'b1 || flag_zero !== 1'b1) begin
      failures++; $display("FAIL flags_hold got=%b%b want=11", flag_carry, flag_zero);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      load_ir = 1'($urandom); load_pc = 1'($urandom);
      jump_ok = 1'($urandom); pc_inc = 1'($urandom);
      reg_we = N'($urandom); do_out = 1'($urandom);
      out_ready = 1'($urandom); overrun_clr = ($urandom_range(0, 7) == 0);
      flag_we = 1'($urandom); carry_in = 1'($urandom);
      zero_in = 1'($urandom);
      dbus = W'($urandom); abus = W'($urandom);
      step();
      if ({ir, pc, regs, qreg, out_valid, out_overrun, flag_carry, flag_zero}
          !== exp_all()) begin
        failures++;
        $display("FAIL random_%0d got ir=%h pc=%h regs=%h q=%h v=%b ov=%b c=%b z=%b want %h",
                 n, ir, pc, regs, qreg, out_valid, out_overrun, flag_carry, flag_zero,
                 exp_all());
      end
      checks++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_pc();
    test_regs_ir();
    test_back_to_back();
    test_overrun();
    test_flags();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
